// File: rtl/fetch_stage_if.sv
// Instruction-memory request channel: the fetch stage is the master and imem
// is the slave. The address is held stable by the master until ready is seen.
interface fetch_stage_if #(
  parameter int PC_WIDTH = 16
);
  logic                req;
  logic [PC_WIDTH-1:0] addr;
  logic [31:0]         rdata;
  logic                ready;

  modport master (
    output req,
    output addr,
    input  rdata,
    input  ready
  );

  modport slave (
    input  req,
    input  addr,
    output rdata,
    output ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues imem requests, and loads the
// IF/ID register with stall holding, branch redirect/flush and wait-state support.
module fetch_stage #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_stage_if.master        imem,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [PC_WIDTH-1:0]  branch_target,
  output logic [31:0]          if_id_instr,
  output logic [PC_WIDTH-1:0]  if_id_pc,
  output logic                 if_id_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    KILL  = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [PC_WIDTH-1:0] pc, pc_next;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] pending, pending_next;
  logic [PC_WIDTH-1:0] hold_pc, hold_pc_next;
  logic [31:0]         hold_instr, hold_instr_next;
  logic                hold_valid, hold_valid_next;
  logic [31:0]         if_id_instr_next;
  logic [PC_WIDTH-1:0] if_id_pc_next;
  logic                if_id_valid_next;

  assign pc_inc    = pc + 1'b1;
  assign imem.req  = (state == FETCH) || (state == KILL);
  // In KILL the pc is left at the abandoned address, so addr stays stable
  // until the outstanding transfer drains; the redirect target waits in pending.
  assign imem.addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pending     <= RESET_PC;
      hold_pc     <= '0;
      hold_instr  <= 32'h0;
      hold_valid  <= 1'b0;
      if_id_instr <= 32'h0;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      pending     <= pending_next;
      hold_pc     <= hold_pc_next;
      hold_instr  <= hold_instr_next;
      hold_valid  <= hold_valid_next;
      if_id_instr <= if_id_instr_next;
      if_id_pc    <= if_id_pc_next;
      if_id_valid <= if_id_valid_next;
    end
  end

  always_comb begin
    state_next       = state;
    pc_next          = pc;
    pending_next     = pending;
    hold_pc_next     = hold_pc;
    hold_instr_next  = hold_instr;
    hold_valid_next  = hold_valid;
    if_id_instr_next = if_id_instr;
    if_id_pc_next    = if_id_pc;
    if_id_valid_next = if_id_valid;

    unique case (state)
      IDLE: begin
        state_next = FETCH;
      end

      FETCH: begin
        if (branch_taken) begin
          if_id_valid_next = 1'b0;
          if (imem.ready) begin
            pc_next = branch_target;
          end else begin
            pending_next = branch_target;
            state_next   = KILL;
          end
        end else if (imem.ready && !stall) begin
          if_id_instr_next = imem.rdata;
          if_id_pc_next    = pc;
          if_id_valid_next = 1'b1;
          pc_next          = pc_inc;
        end else if (imem.ready) begin
          // Downstream is full: park the returned word instead of refetching.
          hold_instr_next = imem.rdata;
          hold_pc_next    = pc;
          hold_valid_next = 1'b1;
          state_next      = HOLD;
        end else if (!stall) begin
          if_id_valid_next = 1'b0;
        end
      end

      HOLD: begin
        if (branch_taken) begin
          hold_valid_next  = 1'b0;
          if_id_valid_next = 1'b0;
          pc_next          = branch_target;
          state_next       = FETCH;
        end else if (!stall && hold_valid) begin
          if_id_instr_next = hold_instr;
          if_id_pc_next    = hold_pc;
          if_id_valid_next = 1'b1;
          hold_valid_next  = 1'b0;
          pc_next          = pc_inc;
          state_next       = FETCH;
        end
      end

      KILL: begin
        if (branch_taken || !stall) begin
          if_id_valid_next = 1'b0;
        end
        if (imem.ready) begin
          pc_next    = branch_taken ? branch_target : pending;
          state_next = FETCH;
        end else if (branch_taken) begin
          pending_next = branch_target;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a hand-derived vector table for the directed corner
// cases, then randomized traffic checked against a transaction-level model.
module tb_fetch_stage;

  localparam int NV     = 28;
  localparam int NRAND  = 4000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [31:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic        if_id_valid;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage_if #(.PC_WIDTH(16)) imem ();

  fetch_stage #(
    .PC_WIDTH (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem          (imem),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        st;
    logic        br;
    logic [15:0] tgt;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_pc;
  } vec_t;

  vec_t vecs [NV];

  // Memory contents are a pure function of the word address.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'hC3A5, a};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic rdy, input logic st, input logic br, input logic [15:0] tgt);
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    imem.ready    = rdy;
    imem.rdata    = rdy ? mem_word(imem.addr) : $urandom;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_req"},   32'(imem.req),    32'h0);
    check_output({tag, "_addr"},  32'(imem.addr),   32'h0);
    check_output({tag, "_valid"}, 32'(if_id_valid), 32'h0);
    check_output({tag, "_pc"},    32'(if_id_pc),    32'h0);
    check_output({tag, "_instr"}, if_id_instr,      32'h0);
  endtask

  // Reference model: tracks what the stage is doing in transaction terms --
  // whether it has started, whether a returned word is parked, whether an
  // abandoned request must be drained, and which address comes next.
  logic        m_started, m_held, m_discard;
  logic [15:0] m_addr, m_tgt, m_held_pc;
  logic        m_valid;
  logic [15:0] m_pc;
  logic [31:0] m_instr;

  task automatic model_reset();
    m_started = 1'b0;
    m_held    = 1'b0;
    m_discard = 1'b0;
    m_addr    = 16'h0000;
    m_tgt     = 16'h0000;
    m_held_pc = 16'h0000;
    m_valid   = 1'b0;
    m_pc      = 16'h0000;
    m_instr   = 32'h0;
  endtask

  task automatic model_step(input logic rdy, input logic st, input logic br, input logic [15:0] tgt);
    if (!m_started) begin
      m_started = 1'b1;
    end else if (m_held) begin
      if (br) begin
        m_held  = 1'b0;
        m_valid = 1'b0;
        m_addr  = tgt;
      end else if (!st) begin
        m_held  = 1'b0;
        m_valid = 1'b1;
        m_pc    = m_held_pc;
        m_instr = mem_word(m_held_pc);
        m_addr  = m_held_pc + 16'd1;
      end
    end else if (m_discard) begin
      if (br) m_tgt = tgt;
      if (br || !st) m_valid = 1'b0;
      if (rdy) begin
        m_addr    = m_tgt;
        m_discard = 1'b0;
      end
    end else begin
      if (br) begin
        m_valid = 1'b0;
        if (rdy) m_addr = tgt;
        else begin
          m_discard = 1'b1;
          m_tgt     = tgt;
        end
      end else if (rdy && !st) begin
        m_valid = 1'b1;
        m_pc    = m_addr;
        m_instr = mem_word(m_addr);
        m_addr  = m_addr + 16'd1;
      end else if (rdy) begin
        m_held    = 1'b1;
        m_held_pc = m_addr;
      end else if (!st) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic compare_model();
    logic e_req;
    e_req = m_started && !m_held;
    check_output("rnd_req", 32'(imem.req), 32'(e_req));
    if (e_req) check_output("rnd_addr", 32'(imem.addr), 32'(m_addr));
    check_output("rnd_valid", 32'(if_id_valid), 32'(m_valid));
    if (m_valid) begin
      check_output("rnd_pc",    32'(if_id_pc), 32'(m_pc));
      check_output("rnd_instr", if_id_instr,   m_instr);
    end
  endtask

  initial begin
    logic        r_rdy, r_st, r_br;
    logic [15:0] r_tgt;

    // rdy, st, br, tgt | expected req, addr, valid, pc (before the coming edge)
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b1, 16'h0000};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h0001};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 16'h0001};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 16'h0001};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 16'h0001};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 16'h0040, 1'b1, 16'h0003, 1'b1, 16'h0002};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 16'h0000};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h0070, 1'b1, 16'h0041, 1'b1, 16'h0040};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 16'h0080, 1'b1, 16'h0041, 1'b0, 16'h0000};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0041, 1'b0, 16'h0000};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0041, 1'b0, 16'h0000};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0080, 1'b0, 16'h0000};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 16'h0080, 1'b0, 16'h0000};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0010, 1'b0, 16'h0000};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0011, 1'b1, 16'h0010};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0011, 1'b0, 16'h0000};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0011, 1'b0, 16'h0000};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0012, 1'b1, 16'h0011};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0012, 1'b1, 16'h0011};
    vecs[21] = '{1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b1, 16'h0013, 1'b1, 16'h0012};
    vecs[22] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 16'h0000};
    vecs[23] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 16'hFFFE};
    vecs[24] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'hFFFF};
    vecs[25] = '{1'b0, 1'b0, 1'b1, 16'h0020, 1'b1, 16'h0001, 1'b1, 16'h0000};
    vecs[26] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0000};
    vecs[27] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0000};

    reset         = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;
    imem.ready    = 1'b0;
    imem.rdata    = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");

    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < NV; i++) begin
      check_output($sformatf("vec%0d_req", i), 32'(imem.req), 32'(vecs[i].e_req));
      if (vecs[i].e_req)
        check_output($sformatf("vec%0d_addr", i), 32'(imem.addr), 32'(vecs[i].e_addr));
      check_output($sformatf("vec%0d_valid", i), 32'(if_id_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        check_output($sformatf("vec%0d_pc", i), 32'(if_id_pc), 32'(vecs[i].e_pc));
        check_output($sformatf("vec%0d_instr", i), if_id_instr, mem_word(vecs[i].e_pc));
      end
      apply_stimulus(vecs[i].rdy, vecs[i].st, vecs[i].br, vecs[i].tgt);
      @(negedge clk);
      #1;
    end

    // Still draining the abandoned request: reset must drop everything at once.
    check_output("kill_req_before_reset", 32'(imem.req), 32'h1);
    reset = 1'b1;
    #1;
    check_reset_values("mid_kill_reset");
    apply_stimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();

    for (int c = 0; c < NRAND; c++) begin
      compare_model();
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        #1;
        check_reset_values("rnd_reset");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
      end else begin
        r_rdy = ($urandom_range(0, 9) < 7);
        r_st  = ($urandom_range(0, 3) == 0);
        r_br  = ($urandom_range(0, 11) == 0);
        if ($urandom_range(0, 1) == 0) r_tgt = 16'hFFF0 | 16'($urandom_range(0, 15));
        else                           r_tgt = 16'($urandom);
        apply_stimulus(r_rdy, r_st, r_br, r_tgt);
        @(posedge clk);
        model_step(r_rdy, r_st, r_br, r_tgt);
        @(negedge clk);
        #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
